jtcop_mcu_bridge: RTL

//  Glue between the main 68000 bus and the i8751 protection/bank MCU port pins.
//  - Captures main-CPU commands and raises MCU INT1 with ack and timeout.
//  - Serves command bytes to P0 on P2 read strobes; assembles the 16-bit MCU reply from P2 write strobes.
//  - Registers ROM-bank flags from P1/P3 for the SDRAM controller.
//  - Sits between jtcop_main (sec/sec2, cpu_dout) and jtframe_8751mcu.

---
 rtl/jtcop_mcu_bridge_pkg.sv | 40 ++++
 rtl/jtcop_mcu_irq.sv | 82 ++++++++
 rtl/jtcop_mcu_bridge.sv | 115 +++++++++++
 3 files changed

// File: rtl/jtcop_mcu_bridge_pkg.sv
// Shared types and constants for the 68000 <-> i8751 MCU bridge.
package jtcop_mcu_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } irq_state_e;

    localparam int unsigned P2_ACK = 3;
    localparam int unsigned P2_RDH = 4;
    localparam int unsigned P2_RDL = 5;
    localparam int unsigned P2_WRL = 6;
    localparam int unsigned P2_WRH = 7;

    localparam int unsigned P1_SND_LSB = 5;
    localparam int unsigned P1_B1_LSB  = 3;
    localparam int unsigned P1_B0      = 2;
    localparam int unsigned P1_MIX_LSB = 0;
    localparam int unsigned P3_CRB_LSB = 0;

    typedef struct packed {
        logic [1:0] sndflag;
        logic [1:0] b1flg;
        logic       b0flg;
        logic [1:0] mixflg;
        logic [2:0] crback;
    } bank_flags_t;

    function automatic bank_flags_t decode_flags(input logic [6:0] p1, input logic [2:0] p3);
        bank_flags_t f;
        f.sndflag = p1[P1_SND_LSB +: 2];
        f.b1flg   = p1[P1_B1_LSB +: 2];
        f.b0flg   = p1[P1_B0];
        f.mixflg  = p1[P1_MIX_LSB +: 2];
        f.crback  = p3[P3_CRB_LSB +: 3];
        return f;
    endfunction

endpackage

// File: rtl/jtcop_mcu_irq.sv
// MCU INT1 request FSM: request/ack handshake, one pending slot and saturating timeout.
module jtcop_mcu_irq
    import jtcop_mcu_bridge_pkg::*;
#(
    parameter int unsigned TOUT_W  = 12,
    parameter bit          TOUT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_rise,
    input  logic ack_n,
    output logic int1n,
    output logic tout
);

    localparam logic [TOUT_W-1:0] CNT_MAX = '1;

    irq_state_e        state_q, state_d;
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic              tout_q, tout_d;
    logic              int1n_q, int1n_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tout_q  <= 1'b0;
            int1n_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tout_q  <= tout_d;
            int1n_q <= int1n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                if (req_rise || pend_q) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                if (req_rise) pend_d = 1'b1;
                if (!ack_n) begin
                    state_d = ACK;
                end else if (TOUT_EN && cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    tout_d  = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + TOUT_W'(1);
                end
            end
            ACK: begin
                if (req_rise) pend_d = 1'b1;
                if (ack_n) begin
                    // a queued request restarts REQ; an edge arriving now waits in IDLE
                    state_d = pend_q ? REQ : IDLE;
                    cnt_d   = '0;
                    pend_d  = pend_q ? 1'b0 : req_rise;
                end
            end
            default: state_d = IDLE;
        endcase
        // low only while REQ is held across the edge, so the request shows one cycle after entry
        int1n_d = !(state_q == REQ && state_d == REQ);
    end

    assign int1n = int1n_q;
    assign tout  = tout_q;

endmodule

// File: rtl/jtcop_mcu_bridge.sv
// Glue between the 68000 bus and the i8751 port pins: command/reply latches, INT1 and bank flags.
module jtcop_mcu_bridge
    import jtcop_mcu_bridge_pkg::*;
#(
    parameter int unsigned TOUT_W  = 12,
    parameter bit          TOUT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  sec,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_dsn,
    output logic [15:0] mcu_dout,
    output logic        rsp_new,
    output logic        tout,
    input  logic [7:0]  p0o,
    input  logic [7:0]  p1o,
    input  logic [7:0]  p2o,
    input  logic [7:0]  p3o,
    output logic [7:0]  p0i,
    output logic [7:0]  p3i,
    output logic        int1n,
    output logic [1:0]  sndflag,
    output logic [1:0]  b1flg,
    output logic        b0flg,
    output logic [1:0]  mixflg,
    output logic [2:0]  crback
);

    logic [7:0]  p2l_q, p2l_d;
    logic        sec0l_q, sec0l_d;
    logic        sec1l_q, sec1l_d;
    logic [15:0] cmd_q, cmd_d;
    logic [7:0]  p0i_q, p0i_d;
    logic [15:0] mcu_dout_q, mcu_dout_d;
    logic        rsp_new_q, rsp_new_d;
    bank_flags_t flags_q, flags_d;

    logic [7:0]  p2_rise_c;
    logic        cmd_rise_c;
    logic        rsp_rise_c;
    logic        unused_c;

    assign p2_rise_c  = p2o & ~p2l_q;
    assign cmd_rise_c = sec[0] & ~sec0l_q;
    assign rsp_rise_c = sec[1] & ~sec1l_q;
    assign unused_c   = ^{sec[2], p1o[7], p3o[7:5], p2_rise_c[3:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p2l_q      <= 8'hFF;
            sec0l_q    <= 1'b0;
            sec1l_q    <= 1'b0;
            cmd_q      <= '0;
            p0i_q      <= '0;
            mcu_dout_q <= '0;
            rsp_new_q  <= 1'b0;
            flags_q    <= '0;
        end else begin
            p2l_q      <= p2l_d;
            sec0l_q    <= sec0l_d;
            sec1l_q    <= sec1l_d;
            cmd_q      <= cmd_d;
            p0i_q      <= p0i_d;
            mcu_dout_q <= mcu_dout_d;
            rsp_new_q  <= rsp_new_d;
            flags_q    <= flags_d;
        end
    end

    always_comb begin
        p2l_d      = p2o;
        sec0l_d    = sec[0];
        sec1l_d    = sec[1];
        cmd_d      = cmd_q;
        p0i_d      = p0i_q;
        mcu_dout_d = mcu_dout_q;
        rsp_new_d  = rsp_new_q;
        flags_d    = decode_flags(p1o[6:0], p3o[2:0]);

        if (cmd_rise_c) begin
            if (!cpu_dsn[1]) cmd_d[15:8] = cpu_dout[15:8];
            if (!cpu_dsn[0]) cmd_d[7:0]  = cpu_dout[7:0];
        end
        if (p2_rise_c[P2_RDH]) p0i_d = cmd_q[15:8];
        if (p2_rise_c[P2_RDL]) p0i_d = cmd_q[7:0];
        if (p2_rise_c[P2_WRL]) mcu_dout_d[7:0]  = p0o;
        if (p2_rise_c[P2_WRH]) mcu_dout_d[15:8] = p0o;
        if (rsp_rise_c)        rsp_new_d = 1'b0;
        if (p2_rise_c[P2_WRH]) rsp_new_d = 1'b1;
    end

    jtcop_mcu_irq #(
        .TOUT_W  (TOUT_W),
        .TOUT_EN (TOUT_EN)
    ) u_irq (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_rise (cmd_rise_c),
        .ack_n    (p2o[P2_ACK]),
        .int1n    (int1n),
        .tout     (tout)
    );

    assign mcu_dout = mcu_dout_q;
    assign rsp_new  = rsp_new_q;
    assign p0i      = p0i_q;
    assign p3i      = {sec[5:3], p3o[4:0]};
    assign sndflag  = flags_q.sndflag;
    assign b1flg    = flags_q.b1flg;
    assign b0flg    = flags_q.b0flg;
    assign mixflg   = flags_q.mixflg;
    assign crback   = flags_q.crback;

endmodule
